flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer (reader) side of the 32-bit processor flag word; the flag register is the writer side.
- Accepts a condition-evaluation request, samples the flag word on the accept edge and evaluates a 4-bit condition code. Returns a registered taken/not-taken result over a valid/ready handshake.
- Raises a trap request, acknowledged by the control unit, for illegal condition codes and, optionally, for overflow.
- Sits between the flag register and the branch/control logic.

Parameters:
- CNT_W, 16, width of the saturating evaluation counter.
- TRAP_CAUSE_W, 2, width of the trap cause field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flag  in  32  flag word. Bit 0 zero (Z), 1 carry (C), 2 integer overflow (V), 3 warning (W), 4 sign (S); all active-high. Bits 31:5 ignored.
- cond_valid  in  1  evaluation request valid.
- cond_ready  out  1  unit can accept a request.
- cond_code  in  4  condition code, sampled with the request.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  condition true.
- trap_req  out  1  trap request, level, held until acknowledged.
- trap_cause  out  TRAP_CAUSE_W  trap cause: 0 none, 1 illegal code, 2 overflow.
- trap_ack  in  1  trap acknowledge.
- eval_cnt  out  CNT_W  count of completed evaluations, saturating.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - cond_ready=1. res_valid, res_taken, trap_req = 0. trap_cause=0. eval_cnt=0.
  - A reset mid-operation abandons any pending result or trap without completing it.
- FSM states: IDLE, RESP, TRAP.
- IDLE:
  - cond_ready=1.
  - On cond_valid&cond_ready at edge N, latch flag[4:0] and cond_code.
  - The registered result appears at edge N, so res_valid=1 in cycle N+1 (latency 1). Next state RESP.
- RESP:
  - cond_ready=0. res_valid=1; res_taken is stable until the handshake.
  - On res_valid&res_ready: eval_cnt increments, saturating at all-ones.
  - If a trap is pending, go to TRAP; otherwise go to IDLE.
  - res_ready may be held high permanently. Throughput is then one evaluation per 2 cycles when no trap occurs.
- TRAP:
  - res_valid=0. trap_req=1 with trap_cause stable.
  - On trap_ack: trap_req=0, trap_cause=0, go to IDLE.
  - trap_ack outside TRAP is ignored.
- Condition codes, evaluated on the latched flags:
  - 0 ALWAYS=1, 1 EQ=Z, 2 NE=!Z, 3 CS=C, 4 CC=!C, 5 VS=V, 6 VC=!V, 7 MI=S, 8 PL=!S.
  - 9 LT=S^V, 10 GE=!(S^V), 11 GT=!Z&!(S^V), 12 LE=Z|(S^V).
  - 13 WS=W, 14 NEVER=0.
  - 15 illegal: res_taken=0 and a trap is pending with cause 1.
- Trap precedence: illegal (1) over overflow (2). At most one trap per evaluation.
- Flag changes after the accept edge do not affect the in-flight result.
- cond_valid while cond_ready=0 is ignored. The requester must hold the request until it is accepted.

Optional Feature:
- Macro: FLAG_TRAP_OVF_EN.
- Defined: an evaluation whose latched V=1 and code ≠ 15 has a pending trap with cause 2, whatever the code's result.
- Undefined: overflow never traps. Cause 2 is never produced. Only code 15 reaches TRAP.

Decomposition:
- Shared package `flag_pkg`:
  - Flag bit index constants: FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_W=3, FLAG_S=4.
  - Condition-code enum (4 bits).
  - Trap-cause enum.
  - FSM state typedef.
- Natural sub-module `flag_cond_eval`: purely combinational mapping of (flags[4:0], code) to (taken, illegal). It is instantiated once on the latched values.

Test Plan:
1. Reset mid-RESP: assert rst with res_valid=1 -> same cycle res_valid=0, trap_req=0, eval_cnt=0; after release cond_ready=1.
2. Zero flag: flag=32'h1, code=1 (EQ), res_ready=1 -> res_valid one cycle after accept, res_taken=1; code=2 -> res_taken=0; eval_cnt=2.
3. Signed compare: flag=32'h10 (S=1, V=0), code=9 (LT) -> taken=1. flag=32'h14 (S=1, V=1), code=11 (GT) -> taken=1. Same flags, code=12 (LE) -> taken=0.
4. Illegal code: code=15 -> res_taken=0, then trap_req=1 with cause=1. Hold trap_ack=0 for 5 cycles -> trap_req stays 1 and cond_ready stays 0. Pulse trap_ack -> back to IDLE.
5. Overflow: flag=32'h4, code=0 -> with FLAG_TRAP_OVF_EN, taken=1 then trap cause=2; without the macro, taken=1 and no trap. Change flag to 0 the cycle after accept -> result unchanged.
6. Backpressure and saturation: hold res_ready=0 for 10 cycles -> res_valid and res_taken stable and a second cond_valid is not accepted. Preload eval_cnt to all-ones via repeated evaluations -> stays all-ones.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared definitions for the flag consumer: flag bit positions, condition codes,
// trap causes and the condition-unit FSM state.
package flag_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_W = 3;
  localparam int FLAG_S = 4;

  typedef enum logic [3:0] {
    CC_AL  = 4'd0,
    CC_EQ  = 4'd1,
    CC_NE  = 4'd2,
    CC_CS  = 4'd3,
    CC_CC  = 4'd4,
    CC_VS  = 4'd5,
    CC_VC  = 4'd6,
    CC_MI  = 4'd7,
    CC_PL  = 4'd8,
    CC_LT  = 4'd9,
    CC_GE  = 4'd10,
    CC_GT  = 4'd11,
    CC_LE  = 4'd12,
    CC_WS  = 4'd13,
    CC_NV  = 4'd14,
    CC_ILL = 4'd15
  } cond_code_e;

  typedef enum logic [1:0] {
    TC_NONE    = 2'd0,
    TC_ILLEGAL = 2'd1,
    TC_OVF     = 2'd2
  } trap_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational condition evaluator: maps latched flags and a condition code
// to taken/illegal. Zero latency, no handshake.
module flag_cond_eval
  import flag_pkg::*;
(
  input  logic [4:0] flags,
  input  logic [3:0] code,
  output logic       taken,
  output logic       illegal
);

  logic z, c, v, w, s, lt;

  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign w  = flags[FLAG_W];
  assign s  = flags[FLAG_S];
  assign lt = s ^ v;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (code)
      CC_AL:   taken = 1'b1;
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_VS:   taken = v;
      CC_VC:   taken = !v;
      CC_MI:   taken = s;
      CC_PL:   taken = !s;
      CC_LT:   taken = lt;
      CC_GE:   taken = !lt;
      CC_GT:   taken = !z && !lt;
      CC_LE:   taken = z || lt;
      CC_WS:   taken = w;
      CC_NV:   taken = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Flag-word consumer: evaluates a condition code on flags sampled at accept,
// returns the result one cycle later over valid/ready and raises traps.
// Define FLAG_TRAP_OVF_EN to also trap (cause 2) on a latched overflow flag.
module flag_cond_unit
  import flag_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int TRAP_CAUSE_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             flag,
  input  logic                    cond_valid,
  output logic                    cond_ready,
  input  logic [3:0]              cond_code,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    res_taken,
  output logic                    trap_req,
  output logic [TRAP_CAUSE_W-1:0] trap_cause,
  input  logic                    trap_ack,
  output logic [CNT_W-1:0]        eval_cnt
);

  state_e      state_q, state_d;
  logic [4:0]  flags_q;
  logic [3:0]  code_q;
  logic        taken_w, illegal_w, ovf_trap;
  trap_cause_e pend_cause;
  logic        flag_unused;

  assign flag_unused = ^flag[31:5];

  flag_cond_eval u_eval (
    .flags   (flags_q),
    .code    (code_q),
    .taken   (taken_w),
    .illegal (illegal_w)
  );

`ifdef FLAG_TRAP_OVF_EN
  assign ovf_trap = flags_q[FLAG_V];
`else
  assign ovf_trap = 1'b0;
`endif

  // Illegal code wins over overflow; only one cause per evaluation.
  always_comb begin
    pend_cause = TC_NONE;
    if (illegal_w)     pend_cause = TC_ILLEGAL;
    else if (ovf_trap) pend_cause = TC_OVF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      flags_q <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && cond_valid) begin
        flags_q <= flag[4:0];
        code_q  <= cond_code;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cond_valid) state_d = ST_RESP;
      ST_RESP: if (res_ready)  state_d = (pend_cause != TC_NONE) ? ST_TRAP : ST_IDLE;
      ST_TRAP: if (trap_ack)   state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cond_ready = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    trap_req   = 1'b0;
    trap_cause = '0;
    case (state_q)
      ST_IDLE: cond_ready = 1'b1;
      ST_RESP: begin
        res_valid = 1'b1;
        res_taken = taken_w;
      end
      ST_TRAP: begin
        trap_req   = 1'b1;
        trap_cause = TRAP_CAUSE_W'(pend_cause);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_cnt <= '0;
    end else if (state_q == ST_RESP && res_ready && eval_cnt != '1) begin
      eval_cnt <= eval_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit; counter narrowed to 4 bits so saturation
// is reachable quickly.
module tb_flag_cond_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] flag = '0;
  logic        cond_valid = 1'b0;
  logic        cond_ready;
  logic [3:0]  cond_code = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_taken;
  logic        trap_req;
  logic [1:0]  trap_cause;
  logic        trap_ack = 1'b0;
  logic [3:0]  eval_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

`ifdef FLAG_TRAP_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  flag_cond_unit #(.CNT_W(4), .TRAP_CAUSE_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flag       (flag),
    .cond_valid (cond_valid),
    .cond_ready (cond_ready),
    .cond_code  (cond_code),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_taken  (res_taken),
    .trap_req   (trap_req),
    .trap_cause (trap_cause),
    .trap_ack   (trap_ack),
    .eval_cnt   (eval_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bump_cnt();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  // One full request/response (and trap, if expected) with res_ready held high.
  task automatic run_eval(input string tag, input logic [31:0] f, input logic [3:0] c,
                          input logic exp_taken, input bit chg, input int ack_delay);
    int exp_cause;
    exp_cause = (c == 4'd15) ? 1 : ((OVF_EN && f[2]) ? 2 : 0);
    @(posedge clk); #1;
    flag = f; cond_code = c; cond_valid = 1'b1; res_ready = 1'b1;
    chk({tag, ".cond_ready"}, cond_ready, 1);
    @(posedge clk); #1;
    cond_valid = 1'b0;
    if (chg) flag = '0;
    chk({tag, ".res_valid"}, res_valid, 1);
    chk({tag, ".res_taken"}, res_taken, exp_taken);
    @(posedge clk); #1;
    bump_cnt();
    chk({tag, ".eval_cnt"}, eval_cnt, exp_cnt);
    if (exp_cause != 0) begin
      for (int i = 0; i <= ack_delay; i++) begin
        chk({tag, ".trap_req"}, trap_req, 1);
        chk({tag, ".trap_cause"}, trap_cause, exp_cause);
        chk({tag, ".trap_busy"}, cond_ready, 0);
        chk({tag, ".trap_no_res"}, res_valid, 0);
        if (i < ack_delay) begin
          @(posedge clk); #1;
        end
      end
      trap_ack = 1'b1;
      @(posedge clk); #1;
      trap_ack = 1'b0;
      chk({tag, ".trap_cause_clr"}, trap_cause, 0);
    end
    chk({tag, ".idle_ready"}, cond_ready, 1);
    chk({tag, ".no_trap"}, trap_req, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst.cond_ready", cond_ready, 1);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_taken", res_taken, 0);
    chk("rst.trap_req", trap_req, 0);
    chk("rst.trap_cause", trap_cause, 0);
    chk("rst.eval_cnt", eval_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Zero flag
    run_eval("eq", 32'h1, 4'd1, 1'b1, 1'b0, 0);
    run_eval("ne", 32'h1, 4'd2, 1'b0, 1'b0, 0);
    chk("eq_ne.cnt2", eval_cnt, 2);

    // Signed compares
    run_eval("lt", 32'h10, 4'd9, 1'b1, 1'b0, 0);
    run_eval("gt", 32'h14, 4'd11, 1'b1, 1'b0, 0);
    run_eval("le", 32'h14, 4'd12, 1'b0, 1'b0, 0);
    run_eval("cs", 32'h2, 4'd3, 1'b1, 1'b0, 0);
    run_eval("ws", 32'h8, 4'd13, 1'b1, 1'b0, 0);
    run_eval("nv", 32'h1F, 4'd14, 1'b0, 1'b0, 0);

    // Illegal code, ack held off for 5 cycles
    run_eval("ill", 32'h0, 4'd15, 1'b0, 1'b0, 5);

    // Overflow; flag cleared right after accept must not disturb result
    run_eval("ovf", 32'h4, 4'd0, 1'b1, 1'b1, 0);

    // trap_ack outside TRAP is ignored
    @(posedge clk); #1 trap_ack = 1'b1;
    @(posedge clk); #1 trap_ack = 1'b0;
    chk("stray_ack.ready", cond_ready, 1);
    chk("stray_ack.trap", trap_req, 0);

    // Reset while a result is pending
    @(posedge clk); #1;
    flag = 32'h1; cond_code = 4'd1; cond_valid = 1'b1;
    @(posedge clk); #1;
    cond_valid = 1'b0; res_ready = 1'b0;
    chk("midrst.pre_valid", res_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.res_valid", res_valid, 0);
    chk("midrst.trap_req", trap_req, 0);
    chk("midrst.eval_cnt", eval_cnt, 0);
    exp_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst.cond_ready", cond_ready, 1);
    chk("midrst.idle", res_valid, 0);

    // Backpressure: second request held while result is stalled
    @(posedge clk); #1;
    flag = 32'h1; cond_code = 4'd1; cond_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    flag = 32'h0; cond_code = 4'd2;
    for (int i = 0; i < 10; i++) begin
      chk("bp.res_valid", res_valid, 1);
      chk("bp.res_taken", res_taken, 1);
      chk("bp.cond_ready", cond_ready, 0);
      chk("bp.eval_cnt", eval_cnt, exp_cnt);
      @(posedge clk); #1;
    end
    cond_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    bump_cnt();
    chk("bp.done_cnt", eval_cnt, exp_cnt);
    chk("bp.done_valid", res_valid, 0);
    chk("bp.done_ready", cond_ready, 1);

    // Saturate the 4-bit counter
    for (int i = 0; i < 16; i++) run_eval("sat", 32'h0, 4'd0, 1'b1, 1'b0, 0);
    chk("sat.all_ones", eval_cnt, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
